// File: rtl/delay_pkg.sv
// Shared definitions for the tapped delay line: tap-select width and the
// per-stage record (data + valid).
package delay_pkg;

  localparam int MAX_W = 64;

  function automatic int selw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Data is carried at MAX_W and truncated to WIDTH at the point of use.
  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             valid;
  } stage_rec_t;

endpackage

// File: rtl/delay_stage.sv
// One register stage of the delay line: holds data + valid, clears to RVAL/0
// on reset or flush, loads on enable.
module delay_stage
  import delay_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] RVAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (flush) begin
      data_d = RVAL;
      vld_d  = 1'b0;
    end else if (en) begin
      data_d = d;
      vld_d  = d_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= RVAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q       = data_q;
  assign q_valid = vld_q;

endmodule

// File: rtl/delay_line.sv
// Tapped delay line: DEPTH enable-gated stages, a select mux with a zero-latency
// bypass at sel=0, and a registered count of valid stages.
module delay_line
  import delay_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] RVAL  = '0,
  localparam int              SELW  = selw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] i,
  input  logic             i_valid,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  output logic [SELW-1:0]  occ
);

  logic [DEPTH-1:0][WIDTH-1:0] sd;
  logic [DEPTH-1:0]            sv;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      delay_stage #(.WIDTH(WIDTH), .RVAL(RVAL)) u_stage (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .d(i), .d_valid(i_valid), .q(sd[g]), .q_valid(sv[g])
      );
    end else begin : g_tail
      delay_stage #(.WIDTH(WIDTH), .RVAL(RVAL)) u_stage (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .d(sd[g-1]), .d_valid(sv[g-1]), .q(sd[g]), .q_valid(sv[g])
      );
    end
  end

  // Tap 0 is the live input; tap k is stage k-1.
  stage_rec_t      taps [DEPTH+1];
  stage_rec_t      tap_sel;
  logic [SELW-1:0] idx;

  always_comb begin
    taps[0].data  = MAX_W'(i);
    taps[0].valid = i_valid;
    for (int k = 1; k <= DEPTH; k++) begin
      taps[k].data  = MAX_W'(sd[k-1]);
      taps[k].valid = sv[k-1];
    end
  end

  assign idx     = (sel > SELW'(DEPTH)) ? SELW'(DEPTH) : sel;
  assign tap_sel = taps[idx];
  assign o       = tap_sel.data[WIDTH-1:0];
  assign o_valid = tap_sel.valid;

  // One in, one out on each enabled edge keeps the count exact without a popcount.
  logic [SELW-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (flush)   occ_d = '0;
    else if (en) occ_d = occ_q + SELW'(i_valid) - SELW'(sv[DEPTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst) occ_q <= '0;
    else      occ_q <= occ_d;
  end

  assign occ = occ_q;

endmodule

// File: tb/tb_delay_line.sv
// Directed bench for delay_line (WIDTH=8, DEPTH=4, RVAL=0xA5): a history-list
// model checked every cycle, plus hand-computed literal expectations.
module tb_delay_line;

  localparam int         W    = 8;
  localparam int         D    = 4;
  localparam logic [7:0] RV   = 8'hA5;
  localparam int         SELW = 3;

  logic            clk = 1'b0;
  logic            rst, en, flush, i_valid;
  logic [W-1:0]    i;
  logic [SELW-1:0] sel;
  logic [W-1:0]    o;
  logic            o_valid;
  logic [SELW-1:0] occ;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  delay_line #(.WIDTH(W), .DEPTH(D), .RVAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .i(i), .i_valid(i_valid),
    .sel(sel), .o(o), .o_valid(o_valid), .occ(occ)
  );

  always #5 clk = ~clk;

  // Model: newest-first list of captured {data,valid}; missing entries read as RVAL/invalid.
  logic [W:0] hist[$];

  always @(posedge clk) begin
    if (!rst || flush) hist.delete();
    else if (en) begin
      hist.push_front({i, i_valid});
      if (hist.size() > D) void'(hist.pop_back());
    end
  end

  function automatic logic [W:0] model_tap(input int k);
    if (k == 0) return {i, i_valid};
    if (k <= hist.size()) return hist[k-1];
    return {RV, 1'b0};
  endfunction

  function automatic int model_occ();
    int n = 0;
    foreach (hist[j]) if (hist[j][0]) n++;
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      int         k;
      logic [W:0] t;
      k = (int'(sel) > D) ? D : int'(sel);
      t = model_tap(k);
      check("model_o", 32'(o), 32'(t[W:1]));
      check("model_o_valid", 32'(o_valid), 32'(t[0]));
      check("model_occ", 32'(occ), 32'(model_occ()));
    end
  end

  task automatic drive(input logic r, input logic e, input logic f,
                       input logic [W-1:0] d, input logic v);
    rst = r; en = e; flush = f; i = d; i_valid = v;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tap(input string nm, input int s, input logic [W-1:0] eo, input logic ev);
    sel = SELW'(s);
    #1;
    check({nm, "_o"}, 32'(o), 32'(eo));
    check({nm, "_v"}, 32'(o_valid), 32'(ev));
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] seq_d [6];
  logic       seq_v [6];
  logic [7:0] seq_e [6];
  logic [7:0] en_d  [5];
  logic       en_p  [5];
  logic [7:0] en_e  [5];

  initial begin
    sel = '0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc();
    cyc();
    chk_on = 1'b1;

    // Reset state: all taps RVAL/invalid, bypass follows i.
    drive(1'b1, 1'b0, 1'b0, 8'h3C, 1'b1);
    cyc();
    check("rst_occ", 32'(occ), 32'd0);
    for (int s = 1; s <= D; s++) tap("rst_tap", s, RV, 1'b0);
    tap("rst_bypass", 0, 8'h3C, 1'b1);
    i = 8'h5A; i_valid = 1'b0;
    tap("rst_bypass2", 0, 8'h5A, 1'b0);

    // Latency 3 at sel=3.
    seq_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    seq_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    seq_e = '{8'hA5, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
    sel = 3'd3;
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, 1'b1, 1'b0, seq_d[n], seq_v[n]);
      cyc();
      tap("lat3", 3, seq_e[n], n >= 2);
      if (n == 3) check("lat3_occ_full", 32'(occ), 32'd4);
      if (n == 4) check("lat3_occ_drain", 32'(occ), 32'd3);
    end

    // Enable pattern 1,0,0,1,1: held inputs are not captured.
    do_reset();
    cyc();
    en_d = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    en_p = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    en_e = '{8'h51, 8'h51, 8'h51, 8'h54, 8'h55};
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, en_p[n], 1'b0, en_d[n], 1'b1);
      cyc();
      tap("en_hold", 1, en_e[n], 1'b1);
    end
    check("en_occ", 32'(occ), 32'd3);
    tap("en_order2", 2, 8'h54, 1'b1);
    tap("en_order3", 3, 8'h51, 1'b1);
    tap("en_order4", 4, RV, 1'b0);

    // Flush with en=1 after a full load.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(8'h61 + n), 1'b1);
      cyc();
    end
    check("fl_occ_full", 32'(occ), 32'd4);
    tap("fl_pre", 4, 8'h61, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 8'h99, 1'b1);
    cyc();
    check("fl_occ", 32'(occ), 32'd0);
    for (int s = 1; s <= D; s++) tap("fl_tap", s, RV, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc();
    tap("fl_nocap", 1, RV, 1'b0);

    // Saturated wrap, sel clamp and live sel switch.
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(8'h70 + n), 1'b1);
      cyc();
    end
    check("wrap_occ", 32'(occ), 32'd4);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tap("clamp4", 4, 8'h71, 1'b1);
    tap("clamp7", 7, 8'h71, 1'b1);
    tap("clamp5", 5, 8'h71, 1'b1);
    tap("swap1", 1, 8'h74, 1'b1);
    tap("swap4", 4, 8'h71, 1'b1);
    check("swap_occ", 32'(occ), 32'd4);

    // Reset beats flush and en, then capture resumes.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(8'hC0 + n), 1'b1);
      cyc();
    end
    check("rr_occ3", 32'(occ), 32'd3);
    drive(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1);
    cyc();
    check("rr_occ0", 32'(occ), 32'd0);
    tap("rr_tap1", 1, RV, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'h81, 1'b1);
    cyc();
    tap("rr_cap", 1, 8'h81, 1'b1);
    tap("rr_tap2", 2, RV, 1'b0);
    check("rr_occ1", 32'(occ), 32'd1);

    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have parameter RVAL, default 0, WIDTH-bit data value loaded into every stage on reset/flush.
REQ-004 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous, active-low (rst=0 at a clk edge resets).
REQ-006 SHALL have port: en  input  1  advance enable; pipeline shifts only when en=1.
REQ-007 SHALL have port: flush  input  1  synchronous clear of all stages.
REQ-008 SHALL have port: i  input  WIDTH  data in.
REQ-009 SHALL have port: i_valid  input  1  qualifier for i.
REQ-010 SHALL have port: sel  input  SELW  tap select, SELW = clog2(DEPTH+1).
REQ-011 SHALL have port: o  output  WIDTH  selected tap data.
REQ-012 SHALL have port: o_valid  output  1  selected tap valid.
REQ-013 SHALL have port: occ  output  SELW  count of valid stages.

Function
REQ-014 SHALL hold stages s[0..DEPTH-1], each WIDTH data bits plus one valid bit.
REQ-015 SHALL, on edge with en=1, flush=0, rst=1: s[0] <= {i, i_valid}; s[k] <= s[k-1] for k=1..DEPTH-1; oldest stage discarded.
REQ-016 SHALL, on edge with en=0, flush=0, rst=1: hold all stages unchanged; i ignored.
REQ-017 SHALL, sel=0: o=i, o_valid=i_valid combinationally (zero latency bypass, independent of en).
REQ-018 SHALL, sel=k with 1<=k<=DEPTH: o=s[k-1].data, o_valid=s[k-1].valid (latency k advancing cycles).
REQ-019 SHALL clamp sel>DEPTH to DEPTH.
REQ-020 SHALL make sel changes take effect combinationally; no state disturbed by sel.
REQ-021 SHALL, on edge with flush=1: all data <= RVAL, all valid <= 0; flush overrides en; i not captured.
REQ-022 SHALL drive occ = number of stages with valid=1, registered, consistent with stage contents after every edge (range 0..DEPTH).
REQ-023 SHALL, when en=1 with i_valid=1 and s[DEPTH-1] valid, keep occ unchanged (saturated wrap: one in, one out).
REQ-024 SHALL output data from RVAL-loaded stages with o_valid=0; data of invalid stages is don't-care for consumers but SHALL equal RVAL or previously shifted data, never X.

Reset
REQ-025 SHALL, rst=0 at clk edge: all stage data <= RVAL, all valid <= 0, occ <= 0; rst overrides flush and en.
REQ-026 SHALL give, after reset, o=RVAL, o_valid=0 for any sel>=1; o=i, o_valid=i_valid for sel=0.
REQ-027 SHALL allow reset mid-stream; all in-flight data discarded, first post-reset capture on first edge with rst=1, en=1.

Structure
REQ-028 SHALL place SELW computation function and the stage record typedef (data+valid) in shared package delay_pkg.
REQ-029 SHALL implement each stage as sub-module delay_stage (params WIDTH, RVAL; ports clk, rst, en, flush, d, d_valid, q, q_valid), instantiated DEPTH times by generate.
REQ-030 SHALL contain no latches and no combinational loops; bypass path is the only combinational input-to-output path.

Verification
REQ-031 SHALL verify: WIDTH=8, DEPTH=4, sel=3, en=1, i=0x11,0x22,0x33,0x44 valid -> o=0x11 valid on 3rd edge after first capture, then 0x22, 0x33, 0x44.
REQ-032 SHALL verify: en toggled 1,0,0,1 during stream -> outputs hold on en=0 cycles; sequence order preserved, no duplicates or drops among valid outputs.
REQ-033 SHALL verify: RVAL=0xA5, reset released -> o=0xA5, o_valid=0, occ=0 for sel=1..4; sel=0 -> o follows i.
REQ-034 SHALL verify: 4 valid words loaded (occ=4), flush=1 with en=1 -> next edge occ=0, all o_valid=0, o=RVAL; flushing-cycle i not captured.
REQ-035 SHALL verify: sel=7 with DEPTH=4 -> identical output to sel=4; sel switched 1->4 mid-stream -> o changes same cycle, occ unchanged.
REQ-036 SHALL verify: rst=0 and flush=1 and en=1 on same edge while occ=3 -> reset state (occ=0, o=RVAL), then normal capture resumes on next enabled edge.
